// File: rtl/rr_reg_arbiter_pkg.sv
// rr_reg_arbiter_pkg: shared state encoding, width helper and reset values
package rr_reg_arbiter_pkg;
  typedef enum logic {S_IDLE, S_BUSY} state_e;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int ptr_rst(input int n);
    return n - 1;
  endfunction
  localparam logic Q_RST = 1'b0;
endpackage

// File: rtl/rr_reg_arbiter_pick.sv
// rr_pick: round-robin winner search starting just after the last granted index
module rr_pick
  import rr_reg_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 vld_o
);
  localparam int PW = $clog2(N);
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  int off;
  // rotate so bit 0 is the requester after ptr, then take the lowest set bit
  always_comb begin
    dbl = {req_i, req_i};
    rot = N'(dbl >> ((int'(ptr_i) + 1) % N));
    off = 0;
    vld_o = |req_i;
    for (int j = N - 1; j >= 0; j--) if (rot[j]) off = j;
    idx_o = PW'((int'(ptr_i) + 1 + off) % N);
  end
endmodule

// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin sharing of one W-bit register with fixed write occupancy
module rr_reg_arbiter
  import rr_reg_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int HOLD = 1
) (
  input  logic                 C,
  input  logic                 R,
  input  logic [N-1:0]         REQ,
  input  logic [N*W-1:0]       D,
  output logic [N-1:0]         GNT,
  output logic [W-1:0]         Q,
  output logic                 BUSY,
  output logic [$clog2(N)-1:0] PTR
);
  localparam int PW = $clog2(N);
  localparam int CW = cw(HOLD);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] q_q, q_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic vld, arb;

  rr_pick #(.N(N)) u_pick (.req_i(REQ), .ptr_i(ptr_q), .idx_o(idx), .vld_o(vld));

  assign arb = (state_q == S_IDLE) || (cnt_q == '0);

  // arbitrate when idle or when the countdown has expired, otherwise count down
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    q_d = q_q;
    ptr_d = ptr_q;
    gnt_d = '0;
    if (arb && vld) begin
      state_d = S_BUSY;
      cnt_d = CW'(HOLD - 1);
      q_d = D[idx*W +: W];
      ptr_d = idx;
      gnt_d = N'(1) << idx;
    end else if (arb) begin
      state_d = S_IDLE;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge C) begin
    if (!R) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      q_q <= {W{Q_RST}};
      ptr_q <= PW'(ptr_rst(N));
      gnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
    end
  end

  assign GNT = gnt_q;
  assign Q = q_q;
  assign BUSY = (state_q == S_BUSY);
  assign PTR = ptr_q;
endmodule

// File: doc/rr_reg_arbiter.md
# rr_reg_arbiter

- Round-robin arbiter and sequencer that shares one W-bit DFF register, the write port of a register bank built from DFF cells, between N requesters.
- Each cycle it picks one requester and loads that requester's data into the shared register.
- It then holds the register busy for a fixed occupancy time before arbitrating again.
- It sits between requester logic and the mapped DFF bank, and is the standard way to serialise writes into a single stored word.

## Interface

Parameters:
- N, 4, number of requesters (≥2)
- W, 8, data / register width (≥1)
- HOLD, 1, cycles the register is occupied per granted write (≥1)

Ports:
- C  in  1  clock; all state changes on posedge C
- R  in  1  reset; synchronous, active-low (R=0 at a posedge C resets)
- REQ  in  N  request vector, bit i = requester i
- D  in  N*W  write data; requester i at bits [i*W +: W]
- GNT  out  N  one-hot grant pulse, registered
- Q  out  W  shared register contents
- BUSY  out  1  register occupied; no arbitration completes while a write is counting down
- PTR  out  $clog2(N)  index of last granted requester

## Operation

- States:
  - IDLE: no write in progress.
  - BUSY: write occupancy; a countdown CNT runs from HOLD-1 to 0.
- Reset (R=0 at an edge): GNT=0, Q=0, BUSY=0, PTR=N-1, CNT=0, state IDLE. Requester 0 therefore has first priority after reset.
- Arbitration:
  - The search starts at index (PTR+1) mod N and wraps modulo N.
  - The first i with REQ[i]=1 wins.
  - Arbitration is evaluated whenever state=IDLE, or state=BUSY with CNT=0.
- On a win at an edge:
  - GNT set to one-hot(i).
  - Q ← D[i*W +: W].
  - PTR ← i, BUSY ← 1, CNT ← HOLD-1, state BUSY.
- On an edge with no win from an arbitrating state: GNT=0, BUSY=0, state IDLE. Q and PTR hold.
- In BUSY with CNT>0: CNT decrements, GNT=0, Q holds, and REQ is ignored.
- REQ is level-sensitive:
  - A requester keeps REQ high until it sees its GNT bit.
  - It deasserts REQ in the GNT cycle if it has no further write.
  - REQ still high at the next arbitration edge counts as a new request. Rotation then places it last.
- Simultaneous events:
  - R=0 overrides everything, including an arbitration edge.
  - REQ changes during countdown are not latched; only the REQ level at the arbitration edge matters.
- Single requester, HOLD=1: it is granted on every edge.

## Timing

- Grant latency: REQ sampled at edge k (arbitrating state) → GNT, Q and BUSY valid after edge k. GNT is high for exactly one cycle.
- Occupancy: BUSY is high for HOLD cycles after each grant.
- Next arbitration occurs at edge k+HOLD. Back-to-back grants therefore have period HOLD cycles.
- HOLD=1 gives a throughput of one write per cycle.
- All outputs are registered; there is no combinational REQ→GNT path.

## Structure

- Shared package:
  - state encoding IDLE/BUSY as a 1-bit typedef
  - function for $clog2-based PTR/CNT widths
  - reset values of PTR (N-1) and Q (0)
- One sub-module, rr_pick (combinational):
  - inputs: REQ, PTR
  - outputs: winner index and a valid flag
  - rotate-then-priority-encode implementation
- The top level holds the FSM, CNT, Q register and GNT register.

## Test plan

- Reset: hold R=0 for 2 edges with REQ=4'b1111 → GNT=0, Q=0, BUSY=0, PTR=3 throughout.
- Rotation, N=4, HOLD=1, REQ=4'b1111 held, D[i]=8'h10+i → GNT sequence 0001,0010,0100,1000,0001 on consecutive cycles; Q=10,11,12,13,10; BUSY stays 1.
- Occupancy, HOLD=3, single REQ[2] pulse with D[2]=8'hA5 → GNT=0100 for 1 cycle, Q=A5, BUSY high 3 cycles, then 0.
- REQ[1] raised mid-countdown → first grant occurs at that burst's end.
- Wrap and fairness: PTR=3, REQ=4'b1001 → grant 0, then 3, then 0; requester 3 never starved.
- Reset mid-operation: HOLD=4, grant issued, R=0 at second busy edge → next cycle BUSY=0, Q=0, PTR=3.
- After R=1, REQ=4'b0001 → granted on the next edge.
- Idle gap: REQ=0 for 5 cycles after a write of 8'h3C → BUSY=0, GNT=0, Q stays 8'h3C, PTR unchanged.
